// File: rtl/router_1xn.sv
// router_1xn: store-and-forward router, one serial input, NUM_PORTS lanes.
// Packets are buffered whole, checked, then replayed on the header's lane.
module router_1xn #(
    parameter int DATA_W    = 8,
    parameter int NUM_PORTS = 4,
    parameter int BUF_DEPTH = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [DATA_W-1:0]           dut_inp,
    input  logic                        inp_valid,
    output logic [NUM_PORTS*DATA_W-1:0] dut_outp,
    output logic [NUM_PORTS-1:0]        outp_valid,
    output logic                        busy,
    output logic                        error,
    input  logic                        wr,
    input  logic                        rd,
    input  logic [7:0]                  addr,
    input  logic [31:0]                 wdata,
    output logic [31:0]                 rdata
);
    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RECV  = 3'd1,
        CHECK = 3'd2,
        SEND  = 3'd3,
        DROP  = 3'd4
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] dest;
    logic [DATA_W-1:0] len;
    logic [31:0]       tot;
    logic [31:0]       tot_in;
    logic [31:0]       cnt_nx;
    logic              enable;
    logic [NUM_PORTS-1:0] port_mask;
    logic [31:0]       rx_pkt;
    logic [31:0]       drop_pkt;
    logic [DATA_W-1:0] out_byte;
    logic [PW-1:0]     out_sel;
    logic              out_vld;
    logic              dest_ok;
    logic              rx_inc;
    logic              drop_inc;
    logic              clr;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign tot     = 32'(len) + 32'd2;
    assign tot_in  = 32'(dut_inp) + 32'd2;
    assign cnt_nx  = 32'(cnt) + 32'd1;
    assign dest_ok = (32'(dest) < 32'(NUM_PORTS)) && port_mask[dest[PW-1:0]];
    assign clr     = wr && (addr == 8'h00) && wdata[1];
    assign unused_wdata = ^wdata[31:NUM_PORTS];

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, busy/error and counter strobes.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        error     = 1'b0;
        rx_inc    = 1'b0;
        drop_inc  = 1'b0;
        unique case (state)
            IDLE: begin
                busy = !enable;
                if (inp_valid && enable) state_nxt = RECV;
            end
            RECV: begin
                if (!inp_valid) begin
                    state_nxt = DROP;
                end else if (cnt == CW'(1)) begin
                    if (tot_in > 32'(BUF_DEPTH)) state_nxt = DROP;
                    else if (tot_in == 32'd2)    state_nxt = CHECK;
                end else if (cnt_nx == tot) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                busy      = 1'b1;
                state_nxt = dest_ok ? SEND : DROP;
            end
            SEND: begin
                busy = 1'b1;
                if (cnt_nx == tot) begin
                    state_nxt = IDLE;
                    rx_inc    = 1'b1;
                end
            end
            DROP: begin
                busy      = 1'b1;
                error     = 1'b1;
                drop_inc  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (inp_valid && busy) error = 1'b1;
    end

    // Header capture and byte index for both receive and replay.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            dest <= '0;
            len  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (inp_valid && enable) begin
                        dest <= dut_inp;
                        cnt  <= CW'(1);
                    end
                end
                RECV: begin
                    if (inp_valid) begin
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(1)) len <= dut_inp;
                    end
                end
                CHECK:   cnt <= '0;
                SEND:    cnt <= cnt + CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    assign wr_en   = inp_valid && ((state == IDLE && enable) || state == RECV);
    assign wr_addr = (state == IDLE) ? '0 : cnt[AW-1:0];

    // Packet buffer write; no reset needed on storage.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= dut_inp;
    end

    // Registered replay byte, one per SEND cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_vld  <= 1'b0;
            out_byte <= '0;
            out_sel  <= '0;
        end else if (state == SEND) begin
            out_vld  <= 1'b1;
            out_byte <= mem[cnt[AW-1:0]];
            out_sel  <= dest[PW-1:0];
        end else begin
            out_vld  <= 1'b0;
            out_byte <= '0;
        end
    end

    // Fan the replay byte out to its lane; idle lanes stay zero.
    always_comb begin
        dut_outp   = '0;
        outp_valid = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (out_vld && out_sel == PW'(p)) begin
                outp_valid[p]                  = 1'b1;
                dut_outp[p*DATA_W +: DATA_W]   = out_byte;
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enable    <= 1'b1;
            port_mask <= '1;
        end else if (wr) begin
            if (addr == 8'h00) enable    <= wdata[0];
            if (addr == 8'h0C) port_mask <= wdata[NUM_PORTS-1:0];
        end
    end

    // Saturating packet counters; clear beats increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_pkt   <= '0;
            drop_pkt <= '0;
        end else if (clr) begin
            rx_pkt   <= '0;
            drop_pkt <= '0;
        end else begin
            if (rx_inc && rx_pkt != '1)     rx_pkt   <= rx_pkt + 32'd1;
            if (drop_inc && drop_pkt != '1) drop_pkt <= drop_pkt + 32'd1;
        end
    end

    // Read decode.
    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            addr == 8'h00: rd_mux = {31'b0, enable};
            addr == 8'h04: rd_mux = rx_pkt;
            addr == 8'h08: rd_mux = drop_pkt;
            addr == 8'h0C: rd_mux = 32'(port_mask);
            addr == 8'h10: rd_mux = {28'b0, state, busy};
            default:       rd_mux = '0;
        endcase
    end

    // Registered read data; a coincident write keeps the old value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)          rdata <= '0;
        else if (rd && !wr)  rdata <= rd_mux;
    end

endmodule

// File: tb/tb_router_1xn.sv
// tb_router_1xn: randomized scoreboard bench for router_1xn.
// Expected lane bytes are queued at issue time; a monitor pops and compares.
module tb_router_1xn;
    localparam int DW = 8;
    localparam int NP = 4;
    localparam int BD = 64;

    logic             clk;
    logic             reset;
    logic [DW-1:0]    dut_inp;
    logic             inp_valid;
    logic [NP*DW-1:0] dut_outp;
    logic [NP-1:0]    outp_valid;
    logic             busy;
    logic             error;
    logic             wr;
    logic             rd;
    logic [7:0]       addr;
    logic [31:0]      wdata;
    logic [31:0]      rdata;

    router_1xn #(.DATA_W(DW), .NUM_PORTS(NP), .BUF_DEPTH(BD)) dut (
        .clk(clk), .reset(reset), .dut_inp(dut_inp), .inp_valid(inp_valid),
        .dut_outp(dut_outp), .outp_valid(outp_valid), .busy(busy),
        .error(error), .wr(wr), .rd(rd), .addr(addr), .wdata(wdata),
        .rdata(rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         lane;
        logic [7:0] b;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  pkt[$];
    int          n_vec = 0;
    int          n_fail = 0;
    int          err_seen = 0;
    int          exp_err = 0;
    int          exp_rx = 0;
    int          exp_drop = 0;
    logic [3:0]  model_mask = 4'hF;
    logic [31:0] v;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // Monitor: count error cycles, pop one expected byte per valid beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (error === 1'b1) err_seen++;
            if (outp_valid !== '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(outp_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_lane", 32'(outp_valid), 32'd1 << e.lane);
                    check("out_data", dut_outp, 32'(e.b) << (8 * e.lane));
                end
            end
        end
    end

    // Reference model: packet fate from its bytes, mask and buffer size.
    task automatic model_pkt(input logic [7:0] b[$]);
        int t;
        if (b.size() < 2) begin
            exp_drop++; exp_err++; return;
        end
        t = int'(b[1]) + 2;
        if (t > BD || b.size() < t) begin
            exp_drop++; exp_err++; return;
        end
        if (int'(b[0]) < NP && model_mask[b[0][1:0]]) begin
            for (int i = 0; i < t; i++) exp_q.push_back('{int'(b[0]), b[i]});
            exp_rx++;
        end else begin
            exp_drop++; exp_err++;
        end
    endtask

    task automatic drive(input logic [7:0] b[$]);
        foreach (b[i]) begin
            @(posedge clk); #1;
            inp_valid = 1'b1;
            dut_inp   = b[i];
        end
        @(posedge clk); #1;
        inp_valid = 1'b0;
        dut_inp   = '0;
    endtask

    task automatic mkpkt(input logic [7:0] d, input int l, input int n);
        pkt.delete();
        pkt.push_back(d);
        pkt.push_back(8'(l));
        for (int i = 0; i < l; i++) pkt.push_back(8'($urandom));
        while (pkt.size() > n) void'(pkt.pop_back());
    endtask

    task automatic idle_wait(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic csr_wr(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        wr = 1'b1; addr = a; wdata = d;
        @(posedge clk); #1;
        wr = 1'b0;
    endtask

    task automatic csr_rd(input logic [7:0] a, output logic [31:0] d);
        @(posedge clk); #1;
        rd = 1'b1; addr = a;
        @(posedge clk); #1;
        rd = 1'b0;
        d  = rdata;
    endtask

    task automatic finish_pkt(input string name);
        idle_wait(BD + 10);
        check({name, "_drain"}, 32'(exp_q.size()), 32'd0);
        check({name, "_err"}, 32'(err_seen), 32'(exp_err));
    endtask

    initial begin
        bit seen;
        int kind;
        int l;
        int n;
        logic [7:0] d;

        reset = 1'b1; inp_valid = 1'b0; dut_inp = '0;
        wr = 1'b0; rd = 1'b0; addr = '0; wdata = '0;
        #2 reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_outp", dut_outp, 32'd0);
        check("rst_valid", 32'(outp_valid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        csr_rd(8'h00, v); check("rst_ctrl", v, 32'h1);
        csr_rd(8'h0C, v); check("rst_mask", v, 32'hF);
        csr_rd(8'h04, v); check("rst_rx", v, 32'd0);
        csr_rd(8'h08, v); check("rst_drop", v, 32'd0);
        csr_rd(8'h10, v); check("rst_status", v, 32'd0);

        // Basic forward to lane 2 with latency probe.
        pkt.delete();
        pkt.push_back(8'h02); pkt.push_back(8'h03); pkt.push_back(8'hAA);
        pkt.push_back(8'hBB); pkt.push_back(8'hCC);
        model_pkt(pkt);
        drive(pkt);
        @(posedge clk); #1;
        check("lat_gap", 32'(outp_valid), 32'd0);
        @(posedge clk); #1;
        check("lat_first_v", 32'(outp_valid), 32'h4);
        check("lat_first_d", dut_outp, 32'h0002_0000);
        finish_pkt("fwd2");
        csr_rd(8'h04, v); check("fwd2_rx", v, 32'd1);

        // Truncated packet.
        pkt.delete();
        pkt.push_back(8'h01); pkt.push_back(8'h04);
        pkt.push_back(8'h11); pkt.push_back(8'h22);
        model_pkt(pkt);
        drive(pkt);
        finish_pkt("trunc");
        csr_rd(8'h08, v); check("trunc_drop", v, 32'd1);

        // Port mask: lane 1 disabled, lane 3 open.
        csr_wr(8'h0C, 32'hD); model_mask = 4'hD;
        mkpkt(8'h01, 0, 2); model_pkt(pkt); drive(pkt);
        finish_pkt("mask_drop");
        mkpkt(8'h03, 0, 2); model_pkt(pkt); drive(pkt);
        finish_pkt("mask_fwd");

        // Oversize header, extra byte lands in the drop cycle.
        mkpkt(8'h00, 63, 2);
        model_pkt(pkt);
        pkt.push_back(8'h55);
        drive(pkt);
        finish_pkt("oversize");

        // Input held during replay: bytes discarded, stream intact.
        mkpkt(8'h00, 10, 12);
        model_pkt(pkt);
        drive(pkt);
        @(posedge clk); #1;
        inp_valid = 1'b1; dut_inp = 8'h99;
        repeat (3) @(posedge clk);
        #1;
        inp_valid = 1'b0; dut_inp = '0;
        exp_err += 3;
        finish_pkt("hold");

        // Disabled: new byte refused with error.
        csr_wr(8'h00, 32'h0);
        @(posedge clk); #1;
        inp_valid = 1'b1; dut_inp = 8'h02;
        @(negedge clk);
        check("dis_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        inp_valid = 1'b0;
        exp_err += 1;
        finish_pkt("disabled");
        csr_rd(8'h10, v); check("dis_status", v, 32'h1);
        csr_wr(8'h00, 32'h1);

        // Enable dropped mid-packet: the packet still completes.
        mkpkt(8'h00, 8, 10);
        model_pkt(pkt);
        fork
            drive(pkt);
            begin
                repeat (3) @(posedge clk);
                csr_wr(8'h00, 32'h0);
            end
        join
        finish_pkt("en_mid");
        csr_wr(8'h00, 32'h1);

        csr_rd(8'h04, v); check("dir_rx", v, 32'(exp_rx));
        csr_rd(8'h08, v); check("dir_drop", v, 32'(exp_drop));

        // CSR corner cases.
        csr_rd(8'h00, v);
        @(posedge clk); #1;
        wr = 1'b1; rd = 1'b1; addr = 8'h0C; wdata = 32'h5;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b0;
        check("wr_rd_hold", rdata, 32'h1);
        csr_rd(8'h0C, v); check("mask_rb", v, 32'h5);
        csr_wr(8'h14, 32'hFFFF_FFFF);
        csr_rd(8'h14, v); check("unmapped", v, 32'd0);

        // Counter clear.
        csr_wr(8'h00, 32'h3);
        csr_rd(8'h04, v); check("clr_rx", v, 32'd0);
        csr_rd(8'h08, v); check("clr_drop", v, 32'd0);
        csr_rd(8'h00, v); check("clr_ctrl", v, 32'h1);
        exp_rx = 0; exp_drop = 0;

        // Randomized traffic against the model.
        model_mask = 4'($urandom_range(1, 15));
        csr_wr(8'h0C, 32'(model_mask));
        for (int k = 0; k < 40; k++) begin
            kind = $urandom_range(0, 9);
            n    = $urandom_range(0, 6);
            d    = (n == 6) ? 8'h81 : 8'(n);
            if (kind == 0) begin
                mkpkt(d, $urandom_range(63, 255), 2);
            end else if (kind == 1) begin
                l = $urandom_range(0, 40);
                mkpkt(d, l, $urandom_range(1, l + 1));
            end else begin
                l = $urandom_range(0, 40);
                mkpkt(d, l, l + 2);
            end
            model_pkt(pkt);
            drive(pkt);
            idle_wait(60);
            check("rnd_drain", 32'(exp_q.size()), 32'd0);
        end
        check("rnd_err", 32'(err_seen), 32'(exp_err));
        csr_rd(8'h04, v); check("rnd_rx", v, 32'(exp_rx));
        csr_rd(8'h08, v); check("rnd_drop", v, 32'(exp_drop));

        // Asynchronous reset in the middle of a replay.
        csr_wr(8'h0C, 32'hF); model_mask = 4'hF;
        mkpkt(8'h02, 20, 22);
        model_pkt(pkt);
        drive(pkt);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (outp_valid !== '0) seen = 1'b1;
        end
        check("rst_mid_seen", 32'(seen), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(outp_valid), 32'd0);
        check("rst_mid_outp", dut_outp, 32'd0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        csr_rd(8'h10, v); check("rst_mid_status", v, 32'd0);
        csr_rd(8'h04, v); check("rst_mid_rx", v, 32'd0);
        csr_rd(8'h00, v); check("rst_mid_ctrl", v, 32'h1);
        idle_wait(5);
        check("rst_mid_quiet", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/router_1xn.md
Name: router_1xn

Overview:
- Parametrised successor to the 1x1 router: one serial input port, NUM_PORTS output ports, store-and-forward.
- Each packet is buffered whole, checked, then replayed on the output port selected by its header.
- A CSR slave provides enable, port masking, packet counters and status.
- Sits between the TB driver/monitor interface and the downstream port consumers.

Parameters:
- DATA_W, 8, byte/lane width of dut_inp and each output lane.
- NUM_PORTS, 4, number of output ports (2..16).
- BUF_DEPTH, 64, packet buffer depth in DATA_W words; maximum total packet length.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- dut_inp  in  DATA_W  input packet byte.
- inp_valid  in  1  dut_inp valid this cycle.
- dut_outp  out  NUM_PORTS*DATA_W  output lanes; lane p is bits [p*DATA_W +: DATA_W].
- outp_valid  out  NUM_PORTS  per-lane valid.
- busy  out  1  router cannot accept input.
- error  out  1  one-cycle pulse per drop or discarded byte.
- wr  in  1  CSR write strobe.
- rd  in  1  CSR read strobe.
- addr  in  8  CSR byte address.
- wdata  in  32  CSR write data.
- rdata  out  32  CSR read data.

Behaviour:
- Reset values:
  - outputs: dut_outp=0, outp_valid=0, busy=0, error=0, rdata=0.
  - FSM: IDLE.
  - CSRs: CTRL=0x1, PORT_MASK=all ones, counters=0.
- Packet format: byte0 = destination (low log2(NUM_PORTS) bits used; upper bits must be 0), byte1 = payload length L, then L payload bytes. Total length T = L+2.
- FSM states:
  - IDLE -> RECV on inp_valid && enable (byte0 stored).
  - RECV: each inp_valid byte is written to the buffer and the count increments.
    - Count reaches T -> CHECK.
    - inp_valid low before count reaches T -> DROP (truncated).
    - T > BUF_DEPTH (known at byte1) -> DROP.
  - CHECK, 1 cycle -> SEND if dest < NUM_PORTS and PORT_MASK[dest]=1, else DROP.
  - SEND: replays all T bytes (header included) on lane dest, one per cycle, outp_valid[dest] high contiguously. Other lanes stay valid=0 with data 0. After the last byte -> IDLE.
  - DROP, 1 cycle: error=1, DROP_PKT++ -> IDLE.
- Latency: the last input byte is sampled at edge N; the first output byte is visible after edge N+2.
- busy:
  - High in CHECK, SEND and DROP.
  - High in IDLE when enable=0.
  - inp_valid while busy: byte discarded, error pulses that cycle, no counter change.
- RX_PKT increments on the cycle the last SEND byte is driven.
- Counters are 32-bit and saturate at 0xFFFFFFFF.
- enable cleared mid-packet: the current packet completes normally; only new packets are refused.
- Asynchronous reset mid-packet: the packet is abandoned with no counter update; outputs take their reset values immediately.
- CSR map:
  - 0x00 CTRL RW. bit0 enable. bit1 counter clear: write-1, self-clearing, reads 0.
  - 0x04 RX_PKT RO.
  - 0x08 DROP_PKT RO.
  - 0x0C PORT_MASK RW, bits [NUM_PORTS-1:0].
  - 0x10 STATUS RO. bit0 busy. bits[3:1] FSM state encoding: IDLE=0, RECV=1, CHECK=2, SEND=3, DROP=4.
- CSR timing and conflicts:
  - rdata is registered: valid on the cycle after rd and held until the next rd.
  - Unmapped addresses read 0; writes to them are ignored.
  - wr and rd in the same cycle: the write executes and rdata keeps its old value.
  - Counter clear coincident with an increment: clear wins.

Test Plan:
- NUM_PORTS=4; drive 02,03,AA,BB,CC contiguously -> after 2-cycle gap, lane2 outputs 02,03,AA,BB,CC on 5 consecutive cycles; other lanes idle; RX_PKT reads 1.
- Drive 01,04,11,22 then inp_valid low -> DROP, error pulse, DROP_PKT=1, no outp_valid activity.
- Write PORT_MASK=0xD; send packet to dest 1 with L=0 -> dropped, error pulse; same packet to dest 3 -> forwarded on lane3.
- Drive dest 00 with L=63 (T=65 > BUF_DEPTH=64) -> DROP after byte1; inp_valid during DROP -> extra error pulses.
- Send packet, then hold inp_valid during SEND -> those bytes discarded with error per cycle; the SEND stream is intact.
- Write CTRL=0x3 after traffic -> RX_PKT and DROP_PKT read 0, CTRL reads 0x1. Drop reset to 0 mid-SEND -> outp_valid=0 immediately; FSM reads IDLE.
